// File: rtl/param_interval_timer_if.sv
// Control/status bundle between the game FSM and the interval timer.
// master = controller side, slave = timer side.
interface param_interval_timer_if #(
  parameter int WIDTH          = 13,
  parameter int PRESCALE_WIDTH = 8
);
  logic                      Enable;
  logic                      Start;
  logic                      Stop;
  logic                      Mode;
  logic [WIDTH-1:0]          Terminal;
  logic [PRESCALE_WIDTH-1:0] Prescale;
  logic [WIDTH-1:0]          Count;
  logic                      Busy;
  logic                      Done;

  modport master (
    output Enable, Start, Stop, Mode,
    output Terminal, Prescale,
    input  Count, Busy, Done
  );

  modport slave (
    input  Enable, Start, Stop, Mode,
    input  Terminal, Prescale,
    output Count, Busy, Done
  );
endinterface

// File: rtl/param_interval_timer.sv
// Interval timer: prescaled up-count to a latched terminal value,
// one-shot or periodic, with a one-cycle registered Done pulse.
module param_interval_timer #(
  parameter int WIDTH          = 13,
  parameter int PRESCALE_WIDTH = 8
) (
  input logic                   Clock,
  input logic                   Reset,
  param_interval_timer_if.slave tif
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] EXPIRED = 2'd2;

  logic [1:0]                state;
  logic [WIDTH-1:0]          count;
  logic [WIDTH-1:0]          term;
  logic [PRESCALE_WIDTH-1:0] pre;
  logic [PRESCALE_WIDTH-1:0] psc;
  logic                      mode;
  logic                      done;

  logic run;
  logic do_start;
  logic do_stop;
  logic do_count;
  logic tick;
  logic last;

  assign run      = (state == RUN);
  assign do_start = tif.Start;
  assign do_stop  = !tif.Start && tif.Stop && run;
  assign do_count = !tif.Start && !tif.Stop
                    && run && tif.Enable;
  assign tick     = (pre == psc);
  assign last     = (count == term);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      count <= '0;
      term  <= '0;
      pre   <= '0;
      psc   <= '0;
      mode  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (1'b1)
        do_start: begin
          term  <= tif.Terminal;
          psc   <= tif.Prescale;
          mode  <= tif.Mode;
          count <= '0;
          pre   <= '0;
          state <= RUN;
        end
        do_stop: begin
          state <= IDLE;
        end
        do_count: begin
          if (!tick) begin
            pre <= pre + 1'b1;
          end else begin
            pre <= '0;
            if (!last) begin
              count <= count + 1'b1;
            end else begin
              done <= 1'b1;
              // Periodic reload is an explicit clear, never a wrap.
              if (mode) count <= '0;
              else      state <= EXPIRED;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign tif.Count = count;
  assign tif.Busy  = run;
  assign tif.Done  = done;

endmodule

// File: tb/tb_param_interval_timer.sv
// Bench for param_interval_timer: elapsed-cycle reference model,
// directed scenarios and a randomized soak.
module tb_param_interval_timer;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  param_interval_timer_if #(.WIDTH(13), .PRESCALE_WIDTH(8)) tif ();

  param_interval_timer #(.WIDTH(13), .PRESCALE_WIDTH(8)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .tif   (tif.slave)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit chk_on      = 1'b0;

  // Model: a run is fully described by the latched settings and the
  // number n of enabled cycles since Start.
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_EXP  = 2;

  int mst   = M_IDLE;
  int n     = 0;
  int mT    = 0;
  int mP    = 0;
  bit mM    = 1'b0;
  bit mdone = 1'b0;

  function automatic int period();
    return (mT + 1) * (mP + 1);
  endfunction

  function automatic int exp_count();
    int q;
    q = n / (mP + 1);
    if (mM) return q % (mT + 1);
    return (q > mT) ? mT : q;
  endfunction

  always @(posedge Clock) begin
    if (Reset) begin
      mst   <= M_IDLE;
      n     <= 0;
      mT    <= 0;
      mP    <= 0;
      mM    <= 1'b0;
      mdone <= 1'b0;
    end else if (tif.Start) begin
      mT    <= int'(tif.Terminal);
      mP    <= int'(tif.Prescale);
      mM    <= tif.Mode;
      n     <= 0;
      mst   <= M_RUN;
      mdone <= 1'b0;
    end else if (tif.Stop && mst == M_RUN) begin
      mst   <= M_IDLE;
      mdone <= 1'b0;
    end else if (mst == M_RUN && tif.Enable) begin
      n     <= n + 1;
      mdone <= ((n + 1) % period() == 0);
      if (((n + 1) % period() == 0) && !mM) mst <= M_EXP;
    end else begin
      mdone <= 1'b0;
    end
  end

  always @(negedge Clock) begin
    if (chk_on) begin
      vectors += 3;
      if (int'(tif.Count) != exp_count()) begin
        miscompares++;
        $display("FAIL count t=%0t got %0d want %0d",
                 $time, tif.Count, exp_count());
      end
      if (tif.Busy !== (mst == M_RUN)) begin
        miscompares++;
        $display("FAIL busy t=%0t got %b want %b",
                 $time, tif.Busy, (mst == M_RUN));
      end
      if (tif.Done !== mdone) begin
        miscompares++;
        $display("FAIL done t=%0t got %b want %b",
                 $time, tif.Done, mdone);
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic start(int t, int p, bit m);
    tif.Terminal = 13'(t);
    tif.Prescale = 8'(p);
    tif.Mode     = m;
    tif.Start    = 1'b1;
    step();
    tif.Start    = 1'b0;
  endtask

  task automatic wait_done(string name, int lim, int exp);
    int k;
    for (k = 1; k <= lim; k++) begin
      step();
      if (tif.Done) break;
    end
    chk(name, k, exp);
  endtask

  initial begin
    int dq[$];
    tif.Enable   = 1'b1;
    tif.Start    = 1'b0;
    tif.Stop     = 1'b0;
    tif.Mode     = 1'b0;
    tif.Terminal = '0;
    tif.Prescale = '0;
    step();
    chk_on = 1'b1;
    step();
    chk("rst_count", int'(tif.Count), 0);
    chk("rst_busy", int'(tif.Busy), 0);
    chk("rst_done", int'(tif.Done), 0);
    Reset = 1'b0;
    step();

    start(8191, 0, 1'b0);
    wait_done("oneshot_lat", 9000, 8192);
    chk("oneshot_cnt", int'(tif.Count), 8191);
    chk("oneshot_busy", int'(tif.Busy), 0);
    step();
    chk("oneshot_pulse", int'(tif.Done), 0);
    chk("oneshot_hold", int'(tif.Count), 8191);

    start(4, 2, 1'b1);
    for (int k = 1; k <= 46; k++) begin
      step();
      if (tif.Done) dq.push_back(k);
      if (k == 12) chk("per_cnt12", int'(tif.Count), 4);
      if (k == 15) chk("per_cnt15", int'(tif.Count), 0);
    end
    chk("per_npulse", dq.size(), 3);
    if (dq.size() == 3) begin
      chk("per_p1", dq[0], 15);
      chk("per_p2", dq[1], 30);
      chk("per_p3", dq[2], 45);
    end
    chk("per_busy", int'(tif.Busy), 1);

    start(10, 0, 1'b0);
    for (int k = 1; k <= 3; k++) step();
    tif.Enable = 1'b0;
    for (int k = 4; k <= 8; k++) step();
    chk("gap_frozen", int'(tif.Count), 3);
    tif.Enable = 1'b1;
    wait_done("gap_lat", 20, 8);

    start(20, 0, 1'b0);
    for (int k = 1; k <= 7; k++) step();
    chk("stop_pre", int'(tif.Count), 7);
    tif.Stop = 1'b1;
    step();
    tif.Stop = 1'b0;
    chk("stop_cnt", int'(tif.Count), 7);
    chk("stop_busy", int'(tif.Busy), 0);
    for (int k = 0; k < 3; k++) step();
    chk("stop_hold", int'(tif.Count), 7);
    start(20, 0, 1'b0);
    chk("restart_cnt", int'(tif.Count), 0);
    chk("restart_busy", int'(tif.Busy), 1);
    wait_done("restart_lat", 30, 21);

    start(3, 0, 1'b0);
    for (int k = 1; k <= 3; k++) step();
    start(3, 0, 1'b0);
    chk("race_done", int'(tif.Done), 0);
    chk("race_cnt", int'(tif.Count), 0);
    chk("race_busy", int'(tif.Busy), 1);
    step();
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("rst_mid_cnt", int'(tif.Count), 0);
    chk("rst_mid_busy", int'(tif.Busy), 0);
    chk("rst_mid_done", int'(tif.Done), 0);

    start(0, 0, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("t0_done", int'(tif.Done), 1);
      chk("t0_cnt", int'(tif.Count), 0);
    end

    for (int c = 0; c < 4000; c++) begin
      Reset        = ($urandom_range(0, 299) == 0);
      tif.Start    = ($urandom_range(0, 39) == 0);
      tif.Stop     = ($urandom_range(0, 59) == 0);
      tif.Enable   = ($urandom_range(0, 7) != 0);
      tif.Mode     = 1'($urandom_range(0, 1));
      tif.Terminal = 13'($urandom_range(0, 15));
      tif.Prescale = 8'($urandom_range(0, 3));
      step();
    end
    Reset     = 1'b0;
    tif.Start = 1'b0;
    tif.Stop  = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/param_interval_timer.md
Name: param_interval_timer

Overview:
Parametrised interval timer for reaction-timing and delay generation. It generalises the fixed 13-bit all-ones up counter with the following features:
- configurable width
- programmable terminal count
- clock prescaler
- one-shot or periodic mode
- explicit start/stop control
- single-cycle Done pulse

It sits between the game controller FSM (Start/Stop/Mode) and the LED/score logic (Done, Count).

Parameters:
WIDTH, 13, bit width of Count and Terminal.
PRESCALE_WIDTH, 8, bit width of Prescale and the internal prescaler counter.

Ports:
Clock  input  1  system clock, all logic on rising edge.
Reset  input  1  synchronous, active-high reset.
Enable  input  1  count gate; when low, prescaler and Count freeze, state unchanged.
Start  input  1  sampled each cycle; (re)starts a timing run.
Stop  input  1  sampled each cycle; aborts a run in RUN.
Mode  input  1  0 = one-shot, 1 = periodic; latched on Start.
Terminal  input  WIDTH  terminal count; latched on Start.
Prescale  input  PRESCALE_WIDTH  tick divisor minus one; latched on Start.
Count  output  WIDTH  current count value (registered).
Busy  output  1  high while state == RUN.
Done  output  1  registered one-cycle pulse at terminal tick.

Behaviour:
- Reset is synchronous and active-high on Clock. On Reset:
  - state = IDLE
  - Count = 0, prescaler = 0, latched regs = 0
  - Busy = 0, Done = 0
- Priority per edge: Reset > Start > Stop > counting.
- States: IDLE, RUN, EXPIRED.
- Start, in any state:
  - latch Terminal, Prescale and Mode
  - Count <= 0, prescaler <= 0, state <= RUN, Done <= 0
  - Start in RUN restarts cleanly; the in-flight terminal tick on that edge is discarded.
- Stop in RUN:
  - state <= IDLE, Count holds its value, no Done.
  - Stop in IDLE/EXPIRED is ignored.
- Counting in RUN with Enable = 1:
  - If prescaler == latched Prescale: prescaler <= 0 and a tick occurs.
  - Otherwise prescaler increments and there is no tick.
- With Enable = 0: no change to Count or prescaler; Done = 0.
- On a tick:
  - If Count != latched Terminal: Count <= Count + 1.
  - If Count == latched Terminal: Done <= 1 for exactly this one cycle, then:
    - one-shot: state <= EXPIRED, Count holds at Terminal.
    - periodic: Count <= 0, stay in RUN.
- Done is 0 in every cycle not following a terminal tick.
- Latency:
  - Start is sampled at edge 0.
  - Done is high in the cycle after edge (T+1)*(P+1), counted in enabled cycles.
  - Default T = 2^WIDTH-1, P = 0 gives Done after 8192 cycles.
  - Periodic mode gives a Done pulse every (T+1)*(P+1) enabled cycles.
- Terminal = 0: Done after P+1 enabled cycles.
- Count never wraps past Terminal; at all-ones Terminal, the periodic reload is an explicit reset to 0, not an overflow.
- EXPIRED: Count and all outputs hold (Busy = 0, Done = 0) until Start or Reset.
- Busy is combinational from the state register.
- Inputs are not latched outside Start; changing Terminal/Prescale/Mode mid-run has no effect.
- Reset mid-run aborts with no Done pulse.

Test Plan:
- Default params; Prescale = 0, Terminal = 8191, Mode = 0, Enable held 1, Start pulse at cycle 0 -> Done high for exactly 1 cycle after 8192 cycles; Count = 8191 held, Busy = 0, state EXPIRED.
- Terminal = 4, Prescale = 2, Mode = 1 -> Done pulses every 15 cycles, 3 consecutive periods; Count sequence 0,1,2,3,4,0; Busy stays 1.
- Terminal = 10, Prescale = 0, Enable dropped for 5 cycles mid-run -> Done delayed by exactly 5 cycles (at cycle 16); Count frozen during gap.
- Terminal = 20; Stop asserted at cycle 7 -> Busy = 0, Count = 7 held, no Done. Then Start -> Count = 0, new run completes normally.
- Start re-asserted on the exact cycle of the terminal tick -> no Done pulse, Count = 0, Busy = 1. Reset asserted mid-run -> all outputs 0 next cycle.
- Terminal = 0, Prescale = 0, Mode = 1 -> Done high every cycle after the first; Count stays 0.
